// File: rtl/pc_unit.sv
// Fetch-stage PC owner: next-PC selection (ret > call > jmp > branch > seq)
// plus a circular return-address stack that silently overwrites on overflow.
module pc_unit #(
  parameter int PC_W      = 12,
  parameter int RESET_PC  = 0,
  parameter int INC       = 1,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_pc,
  input  logic            jmp,
  input  logic            call,
  input  logic [PC_W-1:0] jmp_pc,
  input  logic            ret,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] npc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [RAS_DEPTH-1:0][PC_W-1:0] ras_q;
  logic [PW-1:0]                  ptr_q;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [PC_W-1:0]                pc_inc;
  logic [PW-1:0]                  ptr_nxt;
  logic                           push, pop, err_d, is_full;

  assign pc_inc  = pc + PC_W'(INC);
  assign ptr_nxt = ptr_q + PTR_ONE;
  assign is_full = (cnt_q == FULL_CNT);

  always_comb begin
    npc   = pc_inc;
    push  = 1'b0;
    pop   = 1'b0;
    err_d = 1'b0;
    if (rst) begin
      npc = PC_W'(RESET_PC);
    end else if (stall) begin
      npc = pc;
    end else if (ret) begin
      // A ret with a simultaneous call never pushes; the pair is flagged.
      if (cnt_q != '0) begin
        npc = ras_q[ptr_q];
        pop = 1'b1;
      end else begin
        err_d = 1'b1;
      end
      if (call) err_d = 1'b1;
    end else if (call) begin
      npc  = jmp_pc;
      push = 1'b1;
    end else if (jmp) begin
      npc = jmp_pc;
    end else if (br_taken) begin
      npc = br_pc;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !is_full) cnt_d = cnt_q + CNT_ONE;
    else if (pop)         cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= PC_W'(RESET_PC);
      ras_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      ras_empty <= 1'b1;
      ras_full  <= 1'b0;
      ras_err   <= 1'b0;
    end else begin
      pc        <= npc;
      cnt_q     <= cnt_d;
      ras_empty <= (cnt_d == '0);
      ras_full  <= (cnt_d == FULL_CNT);
      ras_err   <= err_d;
      // Pointer names the top entry; a push into a full stack lands on the oldest slot.
      if (push) begin
        ras_q[ptr_nxt] <= pc_inc;
        ptr_q          <= ptr_nxt;
      end else if (pop) begin
        ptr_q <= ptr_q - PTR_ONE;
      end
    end
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter register with a parametrised next-PC selector and a small return-address stack (RAS) for call/return. It generalises the two-input branch/sequential PC multiplexer of the RISC datapath into the fetch-stage PC owner, which handles:
- sequential advance
- conditional branch
- absolute jump
- call/return
- pipeline stall

It sits between the control unit and the instruction memory address port. `pc` drives the instruction memory address.

## Interface
Parameters:
- `PC_W`, 12: width of all PC values.
- `RESET_PC`, 0: value loaded into `pc` on reset.
- `INC`, 1: sequential increment, in instruction-address units.
- `RAS_DEPTH`, 4: RAS entries; must be a power of 2, ≥2.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold `pc` and RAS; all other request inputs ignored.
- `br_taken` in 1: conditional branch resolved taken.
- `br_pc` in `PC_W`: branch target.
- `jmp` in 1: unconditional jump to `jmp_pc`.
- `call` in 1: jump to `jmp_pc` and push return address `pc+INC`.
- `jmp_pc` in `PC_W`: jump/call target.
- `ret` in 1: jump to popped RAS top.
- `pc` out `PC_W`: current PC (registered).
- `npc` out `PC_W`: value `pc` takes at next edge (combinational).
- `ras_empty` out 1: RAS holds 0 entries (registered).
- `ras_full` out 1: RAS holds `RAS_DEPTH` entries (registered).
- `ras_err` out 1: one-cycle pulse on RAS misuse (registered).

## Operation
- Next-PC priority, highest first:
  1. `rst`
  2. `stall`
  3. `ret`
  4. `call`
  5. `jmp`
  6. `br_taken`
  7. sequential
- **rst**: `pc`=`RESET_PC`, RAS count=0, pointer=0, `ras_empty`=1, `ras_full`=0, `ras_err`=0.
- **stall**: `npc`=`pc`. No RAS change. `ras_err`=0.
- **ret, RAS non-empty**: `npc`=top entry; count decrements.
- **ret, RAS empty**: `npc`=`pc+INC`; count stays 0; `ras_err` pulses.
- **ret and call both high**: `ret` is serviced and `call` is ignored (no push); `ras_err` pulses.
- **call**: `npc`=`jmp_pc`; push `pc+INC`.
  - Not full: count increments.
  - Full: circular overwrite of the oldest entry; count stays `RAS_DEPTH`; no error (overflow is silent; the oldest return address is lost).
- **jmp**: `npc`=`jmp_pc`. `jmp` together with `call` behaves as `call`.
- **br_taken**: `npc`=`br_pc`.
- **sequential**: `npc`=`pc+INC`.
- Arithmetic: `pc+INC` is computed modulo 2^`PC_W`. `pc`=2^`PC_W`−1 with `INC`=1 wraps to 0 with no flag. The pushed return address uses the same wrapped sum.
- RAS storage: `RAS_DEPTH`×`PC_W` registers, top-of-stack pointer of log2(`RAS_DEPTH`) bits, count of log2(`RAS_DEPTH`)+1 bits. The pointer wraps modulo `RAS_DEPTH`.
- `ras_empty` and `ras_full` are derived from the count registered after the update.

## Timing
- One-cycle latency: a request sampled at edge k appears on `pc` after edge k. `npc` reflects it combinationally in the same cycle as the request.
- Push and pop complete in the same edge as the `pc` update. A `ret` in the cycle immediately after a `call` returns the just-pushed address.
- `ras_err` is high for exactly the cycle after the offending edge, then low unless the misuse repeats.
- Reset mid-operation, including during a stall, discards the RAS contents and takes effect at that edge. The cycle after reset, `pc`=`RESET_PC`.
- `pc` has no combinational path from inputs; only `npc` does.
- All outputs are stable and defined from the first edge with `rst`=1.

## Test plan
- **Reset, then 3 free-run cycles** (`PC_W`=12, `INC`=1): `pc` = 0, 1, 2, 3; `ras_empty`=1.
- **Branch vs sequential**: at `pc`=0x010, `br_taken`=1, `br_pc`=0x100 → `pc`=0x100 next. With `stall`=1 in the same cycle → `pc` stays 0x010.
- **Nested calls and returns**: call→0x200 at `pc`=0x005, then call→0x300 at 0x200, then ret, ret → `pc` sequence 0x200, 0x300, 0x201, 0x006; `ras_empty`=1 at the end.
- **Overflow**: 5 calls with `RAS_DEPTH`=4 from `pc`=0x000, 0x020, 0x040, 0x060, 0x080 → 4 rets return 0x081, 0x061, 0x041, 0x021; a 5th ret pulses `ras_err` and gives `pc`=0x022.
- **Priority and wrap**: `ret`+`call` together with top=0x0AA → `pc`=0x0AA, `ras_err`=1, count decrements by 1. At `pc`=0xFFF sequential → `pc`=0x000.
- **Reset mid-operation**: 2 pushes, then `rst` → `pc`=`RESET_PC`, `ras_empty`=1. A following ret pulses `ras_err`.
